// File: rtl/mux41_arb4_pkg.sv
// ============================================================================
// Module : mux41_arb4_pkg
// Brief  : Shared widths, FSM state encoding and round-robin pick helper for
//          the mux41_arb4 arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux41_arb4_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_IDX_W = 2;
    localparam int DATA_W    = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Walk offsets from the far end so the requester closest to base wins.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(
        input logic [ARB_N-1:0]     req_vec,
        input logic [ARB_IDX_W-1:0] base
    );
        logic [ARB_IDX_W-1:0] idx;
        logic [ARB_IDX_W-1:0] pick;
        pick = base;
        for (int off = ARB_N - 1; off >= 0; off--) begin
            idx = base + ARB_IDX_W'(off);
            if (req_vec[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux41_arb4_mux41_4.sv
// ============================================================================
// Module : mux41_4
// Brief  : Combinational 4:1 mux, DATA_W bits wide, index {s1,s0}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux41_4
    import mux41_arb4_pkg::*;
(
    input  logic              s0,
    input  logic              s1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] e
);

    always_comb begin
        e = a0;
        case ({s1, s0})
            2'b00:   e = a0;
            2'b01:   e = a1;
            2'b10:   e = a2;
            2'b11:   e = a3;
            default: e = a0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux41_arb4.sv
// ============================================================================
// Module : mux41_arb4
// Brief  : Round-robin arbiter sharing one mux41_4 between four requesters,
//          valid/ready downstream, one-hot ack upstream, BURST-bounded tenure.
//          Optional owner lock enabled by defining MUX_ARB_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux41_arb4
    import mux41_arb4_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ARB_N-1:0]  req,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    output logic [ARB_N-1:0]  ack,
    output logic [ARB_N-1:0]  grant,
    output logic              s0,
    output logic              s1,
    output logic [DATA_W-1:0] e,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic              lock
`endif
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BURST - 1);

    arb_state_e             state_q, state_d;
    logic [ARB_N-1:0]       grant_q, grant_d;
    logic [ARB_IDX_W-1:0]   sel_q,   sel_d;
    logic [ARB_IDX_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    logic                   w_owner_req;
    logic                   w_accept;
    logic                   w_lock;
    logic [ARB_IDX_W-1:0]   w_pick;

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_owner_req = |(req & grant_q);
    assign out_valid   = (state_q == ST_GRANT) && w_owner_req;
    assign w_accept    = out_valid && out_ready;
    assign ack         = grant_q & {ARB_N{w_accept}};
    assign grant       = grant_q;
    assign s1          = sel_q[1];
    assign s0          = sel_q[0];
    assign w_pick      = rr_pick(req, ptr_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    grant_d = ARB_N'(1) << w_pick;
                    sel_d   = w_pick;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                // sel_q is left alone on release so s1/s0 only move on IDLE->GRANT.
                if (w_accept) begin
                    if (w_lock) begin
                        if (cnt_q != C_LAST) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (cnt_q == C_LAST) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = sel_q + ARB_IDX_W'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!w_owner_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + ARB_IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    mux41_4 u_mux (
        .s0 (s0),
        .s1 (s1),
        .a0 (a0),
        .a1 (a1),
        .a2 (a2),
        .a3 (a3),
        .e  (e)
    );

endmodule

`default_nettype wire

// File: tb/tb_mux41_arb4.sv
// ============================================================================
// Module : tb_mux41_arb4
// Brief  : Scoreboard bench for mux41_arb4 (BURST=4 and BURST=1 instances, plus
//          a BURST=2 lock instance when MUX_ARB_LOCK_EN is defined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux41_arb4;

    typedef struct {
        int         k;
        int         idx;
        logic [3:0] data;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req [3];
    logic       rdy [3];
    logic [3:0] a0 = 4'b0000;
    logic [3:0] a1 = 4'b1111;
    logic [3:0] a2 = 4'b1000;
    logic [3:0] a3 = 4'b1100;

    logic [3:0] ack0, grant0, e0, ack1, grant1, e1;
    logic       s0_0, s1_0, ov0, s0_1, s1_1, ov1;

    exp_t       sbq [$];
    int         bl [3][4];
    logic [3:0] acked [3];
    int         last_acc [3];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    mux41_arb4 #(.BURST(4), .CNT_W(2)) dut_b4 (
        .clk(clk), .rst_n(rst_n), .req(req[0]),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .ack(ack0), .grant(grant0), .s0(s0_0), .s1(s1_0), .e(e0),
        .out_valid(ov0), .out_ready(rdy[0])
`ifdef MUX_ARB_LOCK_EN
        , .lock(1'b0)
`endif
    );

    mux41_arb4 #(.BURST(1), .CNT_W(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .ack(ack1), .grant(grant1), .s0(s0_1), .s1(s1_1), .e(e1),
        .out_valid(ov1), .out_ready(rdy[1])
`ifdef MUX_ARB_LOCK_EN
        , .lock(1'b0)
`endif
    );

`ifdef MUX_ARB_LOCK_EN
    logic       lock;
    logic [3:0] ack2, grant2, e2;
    logic       s0_2, s1_2, ov2;
    mux41_arb4 #(.BURST(2), .CNT_W(1)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .req(req[2]),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .ack(ack2), .grant(grant2), .s0(s0_2), .s1(s1_2), .e(e2),
        .out_valid(ov2), .out_ready(rdy[2]), .lock(lock)
    );
    always @(negedge clk) mon(2, ack2, grant2, e2, s1_2, s0_2, ov2, rdy[2]);
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic mon(input int k, input logic [3:0] ack_i, input logic [3:0] grant_i,
                       input logic [3:0] e_i, input logic s1_i, input logic s0_i,
                       input logic ov_i, input logic rdy_i);
        exp_t ex;
        if (rst_n !== 1'b1) return;
        if (ov_i && rdy_i) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat dut%0d: got grant %b, expected no beat", k, grant_i);
            end else begin
                ex = sbq.pop_front();
                chk("sb_dut", k, ex.k);
                chk("sb_grant", {28'd0, grant_i}, 32'(1 << ex.idx));
                chk("sb_sel", {30'd0, s1_i, s0_i}, ex.idx);
                chk("sb_data", {28'd0, e_i}, {28'd0, ex.data});
                chk("sb_ack", {28'd0, ack_i}, 32'(1 << ex.idx));
                if (ex.gap != 0) chk("sb_gap", cyc - last_acc[k], ex.gap);
            end
            last_acc[k] = cyc;
            acked[k]    = ack_i;
        end else begin
            chk("ack_idle", {28'd0, ack_i}, 32'd0);
            acked[k] = 4'b0;
        end
    endtask

    always @(negedge clk) mon(0, ack0, grant0, e0, s1_0, s0_0, ov0, rdy[0]);
    always @(negedge clk) mon(1, ack1, grant1, e1, s1_1, s0_1, ov1, rdy[1]);

    // Requester model: hold req[i] until its last beat has been acked.
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (acked[k][i]) begin
                    acked[k][i] = 1'b0;
                    if (bl[k][i] > 0) bl[k][i]--;
                    if (bl[k][i] == 0) req[k][i] = 1'b0;
                end
            end
        end
    end

    task automatic push(input int k, input int idx, input logic [3:0] d, input int gap);
        exp_t ex;
        ex.k = k; ex.idx = idx; ex.data = d; ex.gap = gap;
        sbq.push_back(ex);
    endtask

    task automatic issue(input int k, input int i, input int n);
        bl[k][i]  = n;
        req[k][i] = 1'b1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            req[k]   = 4'b0;
            acked[k] = 4'b0;
            for (int i = 0; i < 4; i++) bl[k][i] = 0;
        end
    endtask

    task automatic wait_idle(input int k);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0 && req[k] == 4'b0) break;
        end
        chk("drain_left", sbq.size(), 0);
        chk("drain_req", {28'd0, req[k]}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        for (int k = 0; k < 3; k++) begin
            rdy[k]      = 1'b1;
            last_acc[k] = 0;
            req[k]      = 4'b1111;
        end
`ifdef MUX_ARB_LOCK_EN
        lock = 1'b0;
`endif
        rst_n = 1'b0;

        // Reset with all requests high
        repeat (2) @(negedge clk);
        chk("rst_grant", {28'd0, grant0}, 0);
        chk("rst_valid", {31'd0, ov0}, 0);
        chk("rst_sel", {30'd0, s1_0, s0_0}, 0);
        chk("rst_ack", {28'd0, ack0}, 0);
        chk("rst_e", {28'd0, e0}, {28'd0, a0});
        chk("rst_grant_b1", {28'd0, grant1}, 0);
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single requester 2, four beats, then release
        @(posedge clk); #1;
        push(0, 2, 4'b1000, 0);
        repeat (3) push(0, 2, 4'b1000, 1);
        issue(0, 2, 4);
        @(negedge clk);
        chk("lat_pre_valid", {31'd0, ov0}, 0);
        @(negedge clk);
        chk("lat_valid", {31'd0, ov0}, 1);
        chk("lat_sel", {30'd0, s1_0, s0_0}, 2);
        chk("lat_e", {28'd0, e0}, 4'b1000);
        wait_idle(0);
        chk("rel_grant", {28'd0, grant0}, 0);
        chk("rel_valid", {31'd0, ov0}, 0);

        // ptr is 3 now: 3 wins over 0, then 0
        @(posedge clk); #1;
        push(0, 3, 4'b1100, 0);
        push(0, 0, 4'b0000, 0);
        issue(0, 0, 1);
        issue(0, 3, 1);
        wait_idle(0);

        // Owner 1 stalled for 10 cycles
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        push(0, 1, 4'b1111, 0);
        push(0, 1, 4'b1111, 1);
        issue(0, 1, 2);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_grant", {28'd0, grant0}, 4'b0010);
            chk("stall_sel", {30'd0, s1_0, s0_0}, 1);
            chk("stall_e", {28'd0, e0}, 4'b1111);
            chk("stall_ack", {28'd0, ack0}, 0);
        end
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("stall_first_ack", {28'd0, ack0}, 4'b0010);
        wait_idle(0);

        // Round robin with BURST=1 and one idle cycle between owners
        @(posedge clk); #1;
        push(1, 0, 4'b0000, 0);
        push(1, 1, 4'b1111, 2);
        push(1, 2, 4'b1000, 2);
        push(1, 3, 4'b1100, 2);
        push(1, 0, 4'b0000, 2);
        issue(1, 0, 2);
        issue(1, 1, 1);
        issue(1, 2, 1);
        issue(1, 3, 1);
        wait_idle(1);

        // Reset in the middle of owner 3's burst
        @(posedge clk); #1;
        push(0, 3, 4'b1100, 0);
        issue(0, 3, 4);
        for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("mid_grant", {28'd0, grant0}, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", {28'd0, grant0}, 0);
        chk("async_valid", {31'd0, ov0}, 0);
        chk("async_ack", {28'd0, ack0}, 0);
        chk("async_sel", {30'd0, s1_0, s0_0}, 0);
        clear_model();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rdy[0] = 1'b1;
        push(0, 0, 4'b0000, 0);
        push(0, 3, 4'b1100, 0);
        issue(0, 0, 1);
        issue(0, 3, 1);
        wait_idle(0);

`ifdef MUX_ARB_LOCK_EN
        // Locked owner 0 keeps the grant past BURST=2 until its req drops
        @(posedge clk); #1;
        lock = 1'b1;
        push(2, 0, 4'b0000, 0);
        repeat (3) push(2, 0, 4'b0000, 1);
        push(2, 3, 4'b1100, 3);
        issue(2, 0, 4);
        issue(2, 3, 1);
        wait_idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
